xulie_detect_param: RTL and testbench
=====================================

Name: xulie_detect_param

Overview:
- Parametrised serial sequence detector; next generation of the fixed 4-bit "1110" detector.
- Pattern width, pattern value, overlap mode and counter width are parameters.
- Adds an input-qualifier strobe, a saturating match counter and an armed status flag.
- Sits on a single-bit serial data path; Dout feeds downstream control logic as a one-cycle match pulse.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..16.
PATTERN, 4'b1110, PAT_W-bit pattern; MSB is the oldest bit received.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = history cleared after each match.
CNT_W, 8, width of the saturating match counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset; all state is cleared while reset=0.
Din  input  1  serial data bit; sampled only when Din_en=1.
Din_en  input  1  qualifier; 0 = cycle ignored, and history, fill and outputs other than Dout hold.
Dout  output  1  registered match pulse, one cycle wide.
match_cnt  output  CNT_W  number of matches since reset; saturates.
armed  output  1  1 when at least PAT_W-1 valid bits are held, so the next valid bit can complete a match.

Behaviour:
- Reset values: Dout=0, match_cnt=0, armed=0, hist=0, fill=0. Reset asserts asynchronously; release is synchronous to clk.
- Storage:
  - hist: PAT_W-bit shift register.
  - fill: counter 0..PAT_W, saturating at PAT_W.
- Per rising edge with Din_en=1:
  - nxt = {hist[PAT_W-2:0], Din}.
  - hit = (nxt == PATTERN) && (fill >= PAT_W-1).
  - hist <= nxt.
  - Dout <= hit.
  - If hit and OVERLAP=0: fill <= 0. Otherwise fill <= min(fill+1, PAT_W).
  - If hit and match_cnt != all-ones: match_cnt <= match_cnt+1.
- Per edge with Din_en=0: Dout <= 0; every other register holds.
- Latency: Dout is high for exactly the clock cycle after the edge that samples the final pattern bit.
- State view:
  - FILLING: fill < PAT_W-1; armed=0.
  - ARMED: fill >= PAT_W-1; armed=1.
  - FILLING to ARMED on the (PAT_W-1)th valid bit.
  - ARMED to FILLING only on reset, or on a hit when OVERLAP=0.
- armed is combinational from fill; it is glitch-free because fill is registered.
- Back-to-back hits with OVERLAP=1 (e.g. pattern 1111 on a constant 1 stream) give Dout high on consecutive cycles. No pulse merging is applied.
- Counter saturation: at all-ones match_cnt holds; Dout still pulses on every hit.
- Reset mid-sequence: partial history is discarded. A match needs PAT_W fresh valid bits after release.
- PATTERN bits above PAT_W are ignored. PAT_W outside 2..16 is a parameter error (elaboration check).

Optional Feature:
Macro XULIE_PROG_PAT_EN.
- Defined:
  - Adds ports pat_load (input, 1 bit) and pat_in (input, PAT_W bits).
  - The active pattern register resets to PATTERN.
  - pat_load=1 at an edge loads pat_in and clears hist, fill and Dout in the same edge; Din is ignored on that edge.
  - The new pattern is compared from the next edge onward.
- Undefined: these ports do not exist, and the pattern is the constant PATTERN.

Test Plan:
1. Defaults, Din_en=1, bits 0,1,0,1,1,1,1,1,0,1,1,1,0,1,0,0 one per clock -> Dout pulses after bits 8 and 12; final match_cnt=2.
2. PATTERN=4'b1010, OVERLAP=1, bits 1,0,1,0,1,0 -> pulses after bits 3 and 5, match_cnt=2. Same stimulus with OVERLAP=0 -> one pulse after bit 3, match_cnt=1.
3. Defaults, bits 1,1,1, then reset=0 for 2 cycles, release, then bit 0 -> no Dout pulse, match_cnt=0, armed=0.
4. Defaults, bits 1,1, then Din_en=0 with Din=0 for 3 cycles, then bits 1,0 with Din_en=1 -> one Dout pulse after the final 0; no pulse in the gap.
5. CNT_W=2, defaults otherwise, stream "1110" repeated 5 times -> 5 Dout pulses, match_cnt saturates at 3. Also check armed rises after the 3rd valid bit.
6. With XULIE_PROG_PAT_EN: load pat_in=4'b0110, then bits 0,1,1,0 -> one pulse. Bits 1,1,1,0 -> no pulse.

Source files
------------

// File: rtl/xulie_detect_param.sv
// Parametrised serial sequence detector: registered one-cycle match pulse,
// saturating match counter and an armed flag. Latency: Dout one cycle after the final pattern bit.
// No backpressure; Din_en=0 freezes history/fill/counter and drops Dout. Optional macro: XULIE_PROG_PAT_EN.
module xulie_detect_param #(
  parameter int          PAT_W   = 4,
  parameter logic [15:0] PATTERN = 16'b1110,
  parameter bit          OVERLAP = 1'b1,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Din,
  input  logic             Din_en,
`ifdef XULIE_PROG_PAT_EN
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
`endif
  output logic             Dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);

  // Reject pattern widths the history/fill logic is not built for.
  generate
    if ((PAT_W < 2) || (PAT_W > 16)) begin : g_bad_pat_w
      $error("xulie_detect_param: PAT_W must be in 2..16");
    end
  endgenerate

  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  nxt;
  logic [PAT_W-1:0]  pat;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;
  logic              hit;

`ifdef XULIE_PROG_PAT_EN
  logic [PAT_W-1:0] pat_reg;

  // Active pattern register; a load takes effect from the following edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_reg <= PATTERN[PAT_W-1:0];
    end else if (pat_load) begin
      pat_reg <= pat_in;
    end
  end

  assign pat = pat_reg;
`else
  assign pat = PATTERN[PAT_W-1:0];
`endif

  // Next history word, match decision and next fill level for a valid bit.
  always_comb begin
    nxt      = {hist[PAT_W-2:0], Din};
    hit      = (nxt == pat) && (fill >= FILL_ARM);
    fill_nxt = fill;
    if (hit && !OVERLAP) begin
      fill_nxt = '0;
    end else if (fill != FILL_MAX) begin
      fill_nxt = fill + FILL_W'(1);
    end
  end

  // History, fill level, match pulse and saturating counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist      <= '0;
      fill      <= '0;
      Dout      <= 1'b0;
      match_cnt <= '0;
    end else begin
`ifdef XULIE_PROG_PAT_EN
      if (pat_load) begin
        hist <= '0;
        fill <= '0;
        Dout <= 1'b0;
      end else
`endif
      if (Din_en) begin
        hist <= nxt;
        fill <= fill_nxt;
        Dout <= hit;
        if (hit && (match_cnt != '1)) begin
          match_cnt <= match_cnt + CNT_W'(1);
        end
      end else begin
        Dout <= 1'b0;
      end
    end
  end

  // Enough valid bits are held that the next one can complete a match.
  assign armed = (fill >= FILL_ARM);

endmodule

// File: tb/tb_xulie_detect_param.sv
// Bench for xulie_detect_param: four parameterisations share one stimulus bus,
// table-driven bit streams plus hand-written reset/qualifier/armed sequences.
// Expected pulses are queued when a bit is driven and popped after the sampling edge.
module tb_xulie_detect_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic din = 1'b0;
  logic din_en = 1'b0;
`ifdef XULIE_PROG_PAT_EN
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
`endif

  logic [3:0] dout_v;
  logic [3:0] armed_v;
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;

  int tests = 0;
  int fails = 0;
  logic exp_q[$];

  // Free-running clock.
  always #5 clk = ~clk;

  xulie_detect_param u0 (
    .clk(clk), .reset(reset), .Din(din), .Din_en(din_en),
`ifdef XULIE_PROG_PAT_EN
    .pat_load(pat_load), .pat_in(pat_in),
`endif
    .Dout(dout_v[0]), .match_cnt(cnt0), .armed(armed_v[0]));

  xulie_detect_param #(.PATTERN(16'b1010), .OVERLAP(1'b1)) u1 (
    .clk(clk), .reset(reset), .Din(din), .Din_en(din_en),
`ifdef XULIE_PROG_PAT_EN
    .pat_load(pat_load), .pat_in(pat_in),
`endif
    .Dout(dout_v[1]), .match_cnt(cnt1), .armed(armed_v[1]));

  xulie_detect_param #(.PATTERN(16'b1010), .OVERLAP(1'b0)) u2 (
    .clk(clk), .reset(reset), .Din(din), .Din_en(din_en),
`ifdef XULIE_PROG_PAT_EN
    .pat_load(pat_load), .pat_in(pat_in),
`endif
    .Dout(dout_v[2]), .match_cnt(cnt2), .armed(armed_v[2]));

  xulie_detect_param #(.CNT_W(2)) u3 (
    .clk(clk), .reset(reset), .Din(din), .Din_en(din_en),
`ifdef XULIE_PROG_PAT_EN
    .pat_load(pat_load), .pat_in(pat_in),
`endif
    .Dout(dout_v[3]), .match_cnt(cnt3), .armed(armed_v[3]));

  typedef struct {
    int          dut;
    int          n;
    logic [31:0] bits;    // MSB-first in time: bit n-1 is driven first
    logic [31:0] pulses;  // expected Dout after each bit, same ordering
    int          cnt;     // expected match_cnt after the stream
  } grp_t;

  grp_t groups[4];

  function automatic int get_cnt(input int d);
    case (d)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b0;
    din    = 1'b0;
    din_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Drive one bit, queue its expected pulse, compare after the sampling edge.
  task automatic step(input int d, input logic b, input logic en, input logic exp, input string name);
    logic e;
    @(negedge clk);
    din    = b;
    din_en = en;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({name, "_queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk(name, int'(dout_v[d]), int'(e));
    end
  endtask

  initial begin
    groups[0] = '{dut: 0, n: 16, bits: 32'b0101111101110100, pulses: 32'b0000000010001000, cnt: 2};
    groups[1] = '{dut: 1, n: 6,  bits: 32'b101010,           pulses: 32'b000101,           cnt: 2};
    groups[2] = '{dut: 2, n: 6,  bits: 32'b101010,           pulses: 32'b000100,           cnt: 1};
    groups[3] = '{dut: 3, n: 20, bits: 32'hEEEEE,            pulses: 32'h11111,            cnt: 3};

    // Reset state of every instance.
    do_reset();
    #1;
    chk("reset_dout", int'(dout_v), 0);
    chk("reset_armed", int'(armed_v), 0);
    chk("reset_cnt0", get_cnt(0), 0);
    chk("reset_cnt3", get_cnt(3), 0);

    // Table-driven streams.
    for (int g = 0; g < 4; g++) begin
      do_reset();
      for (int i = 0; i < groups[g].n; i++) begin
        step(groups[g].dut, groups[g].bits[groups[g].n-1-i], 1'b1,
             groups[g].pulses[groups[g].n-1-i], $sformatf("grp%0d_bit%0d", g, i));
      end
      chk($sformatf("grp%0d_cnt", g), get_cnt(groups[g].dut), groups[g].cnt);
    end

    // Reset mid-sequence discards history and counter.
    do_reset();
    step(0, 1, 1, 0, "rst_a0"); step(0, 1, 1, 0, "rst_a1");
    step(0, 1, 1, 0, "rst_a2"); step(0, 0, 1, 1, "rst_a3");
    step(0, 1, 1, 0, "rst_a4"); step(0, 1, 1, 0, "rst_a5");
    step(0, 1, 1, 0, "rst_a6");
    chk("rst_pre_cnt", get_cnt(0), 1);
    chk("rst_pre_armed", int'(armed_v[0]), 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_async_cnt", get_cnt(0), 0);
    chk("rst_async_armed", int'(armed_v[0]), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step(0, 0, 1, 0, "rst_after_bit");
    chk("rst_after_cnt", get_cnt(0), 0);
    chk("rst_after_armed", int'(armed_v[0]), 0);

    // Qualifier gap: history and fill hold, no pulse in the gap.
    do_reset();
    step(0, 1, 1, 0, "gap_b0"); step(0, 1, 1, 0, "gap_b1");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, $sformatf("gap_idle%0d", i));
    chk("gap_armed_lo", int'(armed_v[0]), 0);
    step(0, 1, 1, 0, "gap_b2");
    chk("gap_armed_hi", int'(armed_v[0]), 1);
    step(0, 0, 1, 1, "gap_b3");
    step(0, 0, 0, 0, "gap_drop");
    chk("gap_cnt", get_cnt(0), 1);

    // Armed rises on the third valid bit (4-bit pattern).
    do_reset();
    step(3, 1, 1, 0, "arm_b0"); step(3, 1, 1, 0, "arm_b1");
    chk("arm_lo", int'(armed_v[3]), 0);
    step(3, 1, 1, 0, "arm_b2");
    chk("arm_hi", int'(armed_v[3]), 1);

    // Non-overlapping mode drops out of armed on a hit.
    do_reset();
    step(2, 1, 1, 0, "novl_b0"); step(2, 0, 1, 0, "novl_b1");
    step(2, 1, 1, 0, "novl_b2");
    chk("novl_armed_hi", int'(armed_v[2]), 1);
    step(2, 0, 1, 1, "novl_b3");
    chk("novl_armed_lo", int'(armed_v[2]), 0);

`ifdef XULIE_PROG_PAT_EN
    // Programmable pattern: load 0110, then match it, then miss the default pattern.
    do_reset();
    step(0, 1, 1, 0, "pl_pre0"); step(0, 1, 1, 0, "pl_pre1");
    step(0, 1, 1, 0, "pl_pre2");
    @(negedge clk);
    pat_load = 1'b1;
    pat_in   = 4'b0110;
    din      = 1'b0;
    din_en   = 1'b1;
    @(posedge clk);
    #1;
    chk("pl_load_dout", int'(dout_v[0]), 0);
    chk("pl_load_armed", int'(armed_v[0]), 0);
    @(negedge clk);
    pat_load = 1'b0;
    step(0, 0, 1, 0, "pl_m0"); step(0, 1, 1, 0, "pl_m1");
    step(0, 1, 1, 0, "pl_m2"); step(0, 0, 1, 1, "pl_m3");
    step(0, 1, 1, 0, "pl_n0"); step(0, 1, 1, 0, "pl_n1");
    step(0, 1, 1, 0, "pl_n2"); step(0, 0, 1, 0, "pl_n3");
    chk("pl_cnt", get_cnt(0), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
